// File: rtl/cache_arbiter_pkg.sv
// cache_arbiter_pkg: shared FSM encoding and cache timing defaults for the cache arbiter
package cache_arbiter_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  // These must match the cache controller's hit/miss timing.
  localparam int HIT_LAT_DEF  = 2;
  localparam int MISS_LAT_DEF = 12;
endpackage

// File: rtl/sat_counter8.sv
// sat_counter8: 8-bit event counter that sticks at 8'hFF
module sat_counter8 (
  input  logic       clk,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] count
);
  always_ff @(posedge clk)
    if (!clr) count <= 8'd0;
    else if (inc && count != 8'hFF) count <= count + 8'd1;
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the single-port cache between fetch (port 0) and data (port 1)
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int a_width   = 8,
  parameter int d_width   = 8,
  parameter int HIT_LAT   = HIT_LAT_DEF,
  parameter int MISS_LAT  = MISS_LAT_DEF,
  parameter int FIXED_PRI = 0
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               req0,
  input  logic               req1,
  input  logic               rw0,
  input  logic               rw1,
  input  logic [a_width-1:0] addr0,
  input  logic [a_width-1:0] addr1,
  input  logic [d_width-1:0] wdata0,
  input  logic [d_width-1:0] wdata1,
  output logic               ack0,
  output logic               ack1,
  output logic [d_width-1:0] rdata0,
  output logic [d_width-1:0] rdata1,
  output logic               hit0,
  output logic               hit1,
  output logic               c_enab,
  output logic               c_rw,
  output logic [a_width-1:0] c_addr,
  output logic [d_width-1:0] c_wdata,
  input  logic [d_width-1:0] c_rdata,
  input  logic               c_hit,
  output logic               busy,
  output logic [7:0]         hit_count,
  output logic [7:0]         miss_count
);
  localparam int CW = $clog2(MISS_LAT + 1);
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          grant, last_grant, winner, hit_end, miss_end;
  always_comb begin
    winner   = (req0 && req1) ? ((FIXED_PRI != 0) ? 1'b0 : ~last_grant) : ~req0;
    hit_end  = state == ST_BUSY && cnt == CW'(HIT_LAT - 1) && c_hit;
    miss_end = state == ST_BUSY && cnt == CW'(MISS_LAT - 1) && !hit_end;
  end
  assign c_enab = state == ST_BUSY;
  assign busy   = state != ST_IDLE;
  always_ff @(posedge clk) begin
    if (!clr) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      c_rw       <= 1'b0;
      c_addr     <= '0;
      c_wdata    <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      hit0       <= 1'b0;
      hit1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (state == ST_IDLE && (req0 || req1)) begin
        state   <= ST_BUSY;
        grant   <= winner;
        cnt     <= '0;
        c_rw    <= winner ? rw1 : rw0;
        c_addr  <= winner ? addr1 : addr0;
        c_wdata <= winner ? wdata1 : wdata0;
      end else if (state == ST_BUSY) begin
        cnt <= cnt + CW'(1);
        if (hit_end || miss_end) begin
          state <= ST_DONE;
          ack0  <= ~grant;
          ack1  <= grant;
          if (grant) hit1 <= hit_end;
          else hit0 <= hit_end;
          // Writes leave the requester's last read data untouched.
          if (!c_rw && grant) rdata1 <= c_rdata;
          if (!c_rw && !grant) rdata0 <= c_rdata;
        end
      end else if (state == ST_DONE) begin
        state      <= ST_IDLE;
        last_grant <= grant;
      end
    end
  end
  sat_counter8 u_hits (
    .clk  (clk),
    .clr  (clr),
    .inc  (hit_end),
    .count(hit_count)
  );
  sat_counter8 u_misses (
    .clk  (clk),
    .clr  (clr),
    .inc  (miss_end),
    .count(miss_count)
  );
endmodule
